operand_fetch_stage: RTL and testbench

//  Decode-to-execute operand stage sitting directly downstream of the 64x32 register file.

---
 rtl/operand_fetch_stage.sv | 126 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads the register file, forwards from EX/MEM and MEM/WB, and stalls on load-use or stale reads.
// Latency is 2 cycles from accept to out_valid, plus 1 after a write-coincident read, plus 1 per load-use cycle.
// Backpressure: in_ready is low while an instruction is in flight unless the held bundle is being handed off.
module operand_fetch_stage #(
    parameter int DW  = 32,
    parameter int AW  = 6,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [AW-1:0]  in_rs,
    input  logic [AW-1:0]  in_rt,
    input  logic [AW-1:0]  in_rd,
    input  logic [OPW-1:0] in_op,
    input  logic           in_is_load,
    output logic [AW-1:0]  rf_rs,
    output logic [AW-1:0]  rf_rt,
    input  logic [DW-1:0]  rf_xrs,
    input  logic [DW-1:0]  rf_xrt,
    input  logic           exm_wr,
    input  logic           exm_is_load,
    input  logic [AW-1:0]  exm_rd,
    input  logic [DW-1:0]  exm_data,
    input  logic           wb_wr,
    input  logic [AW-1:0]  wb_rd,
    input  logic [DW-1:0]  wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_a,
    output logic [DW-1:0]  out_b,
    output logic [AW-1:0]  out_rd,
    output logic [OPW-1:0] out_op,
    output logic           out_is_load,
    output logic           hazard_stall
);

    typedef enum logic [1:0] {EMPTY, FETCH, FULL} state_t;

    state_t         state_q, state_d;
    logic           stale_q, stale_d;
    logic [AW-1:0]  rs_q, rt_q, rd_q;
    logic [OPW-1:0] op_q;
    logic           ld_q;
    logic [DW-1:0]  a_q, b_q;

    logic           accept;
    logic           capture;
    logic           load_use;
    logic [DW-1:0]  fwd_a, fwd_b;

    assign load_use = exm_wr & exm_is_load & ((exm_rd == rs_q) | (exm_rd == rt_q));

    // Youngest producer wins: EX/MEM result, then the value being written back, then the file.
    assign fwd_a = (exm_wr & ~exm_is_load & (exm_rd == rs_q)) ? exm_data :
                   (wb_wr & (wb_rd == rs_q))                  ? wb_data  : rf_xrs;
    assign fwd_b = (exm_wr & ~exm_is_load & (exm_rd == rt_q)) ? exm_data :
                   (wb_wr & (wb_rd == rt_q))                  ? wb_data  : rf_xrt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_valid) state_d = FETCH;
            FETCH:   if (!load_use && !stale_q) state_d = FULL;
            FULL:    if (out_ready) state_d = in_valid ? FETCH : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == EMPTY) | ((state_q == FULL) & out_ready);
        accept       = in_valid & in_ready;
        hazard_stall = (state_q == FETCH) & (load_use | stale_q);
        capture      = (state_q == FETCH) & ~load_use & ~stale_q;
        out_valid    = (state_q == FULL);
        rf_rs        = accept ? in_rs : rs_q;
        rf_rt        = accept ? in_rt : rt_q;
        // Any write cycle while the read is still pending forces one clean re-read.
        stale_d      = wb_wr & (accept | hazard_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q <= '0;
            rt_q <= '0;
            rd_q <= '0;
            op_q <= '0;
            ld_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            if (accept) begin
                rs_q <= in_rs;
                rt_q <= in_rt;
                rd_q <= in_rd;
                op_q <= in_op;
                ld_q <= in_is_load;
            end
            if (capture) begin
                a_q <= fwd_a;
                b_q <= fwd_b;
            end else if ((state_q == FULL) && wb_wr) begin
                if (wb_rd == rs_q) a_q <= wb_data;
                if (wb_rd == rt_q) b_q <= wb_data;
            end
        end
    end

    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_rd      = rd_q;
    assign out_op      = op_q;
    assign out_is_load = ld_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a behavioural 64x32 register file that skips reads on write cycles.
module tb_operand_fetch_stage;

    localparam int DW = 32, AW = 6, OPW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready;
    logic [AW-1:0]  in_rs, in_rt, in_rd;
    logic [OPW-1:0] in_op;
    logic           in_is_load;
    logic [AW-1:0]  rf_rs, rf_rt;
    logic [DW-1:0]  rf_xrs, rf_xrt;
    logic           exm_wr, exm_is_load;
    logic [AW-1:0]  exm_rd;
    logic [DW-1:0]  exm_data;
    logic           wb_wr;
    logic [AW-1:0]  wb_rd;
    logic [DW-1:0]  wb_data;
    logic           out_valid, out_ready;
    logic [DW-1:0]  out_a, out_b;
    logic [AW-1:0]  out_rd;
    logic [OPW-1:0] out_op;
    logic           out_is_load, hazard_stall;

    logic [DW-1:0]  regs [64];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_fetch_stage #(.DW(DW), .AW(AW), .OPW(OPW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_op(in_op), .in_is_load(in_is_load),
        .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_xrs(rf_xrs), .rf_xrt(rf_xrt),
        .exm_wr(exm_wr), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_op(out_op),
        .out_is_load(out_is_load), .hazard_stall(hazard_stall)
    );

    // Register file: a write cycle suppresses that cycle's read, so the data holds.
    always @(posedge clk) begin
        if (wb_wr) begin
            regs[wb_rd] <= wb_data;
        end else begin
            rf_xrs <= regs[rf_rs];
            rf_xrt <= regs[rf_rt];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_op = '0; in_is_load = 1'b0;
        exm_wr = 1'b0; exm_is_load = 1'b0; exm_rd = '0; exm_data = '0;
        wb_wr = 1'b0; wb_rd = '0; wb_data = '0;
        out_ready = 1'b1;
    endtask

    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                         input logic [OPW-1:0] op, input logic ld);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_op = op; in_is_load = ld;
    endtask

    // Inputs are applied 1ns after the edge; checks happen 1ns later, well before the next edge.
    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = '0;
        regs[3] = 32'h11;
        regs[4] = 32'h22;
        rf_xrs = '0;
        rf_xrt = '0;
        rst = 1'b1;
        idle();
        #1;

        // Reset held for two cycles
        next(); next();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", hazard_stall, 0);
        chk("rst_out_a", out_a, 0);
        rst = 1'b0;

        // Plain fetch of R3/R4
        next();
        issue(6'd3, 6'd4, 6'd5, 4'd7, 1'b0);
        #1;
        chk("t2_rf_rs_comb", rf_rs, 3);
        chk("t2_rf_rt_comb", rf_rt, 4);
        next();
        #1;
        chk("t2_valid_c1", out_valid, 0);
        chk("t2_in_ready_fetch", in_ready, 0);
        chk("t2_rf_rs_held", rf_rs, 3);
        next();
        #1;
        chk("t2_valid_c2", out_valid, 1);
        chk("t2_out_a", out_a, 32'h11);
        chk("t2_out_b", out_b, 32'h22);
        chk("t2_out_rd", out_rd, 5);
        chk("t2_out_op", out_op, 7);
        next();
        #1;
        chk("t2_valid_drop", out_valid, 0);

        // EX/MEM beats MEM/WB on the same register
        issue(6'd3, 6'd4, 6'd1, 4'd1, 1'b0);
        next();
        exm_wr = 1'b1; exm_rd = 6'd3; exm_data = 32'hAA;
        wb_wr = 1'b1; wb_rd = 6'd3; wb_data = 32'hBB;
        next();
        #1;
        chk("t3_out_a_exm", out_a, 32'hAA);
        chk("t3_out_b_rf", out_b, 32'h22);
        next();

        // Load-use stall for two cycles, then write-back forwarding; R3 is now BB
        issue(6'd3, 6'd4, 6'd2, 4'd2, 1'b0);
        next();
        exm_wr = 1'b1; exm_is_load = 1'b1; exm_rd = 6'd4;
        #1;
        chk("t4_stall1", hazard_stall, 1);
        next();
        exm_wr = 1'b1; exm_is_load = 1'b1; exm_rd = 6'd4;
        #1;
        chk("t4_stall2", hazard_stall, 1);
        chk("t4_valid_in_stall", out_valid, 0);
        next();
        wb_wr = 1'b1; wb_rd = 6'd4; wb_data = 32'h55;
        #1;
        chk("t4_stall_clear", hazard_stall, 0);
        next();
        #1;
        chk("t4_valid", out_valid, 1);
        chk("t4_out_b_wb", out_b, 32'h55);
        chk("t4_out_a_rf", out_a, 32'hBB);
        next();

        // Accept coincident with a write to R3: one extra fetch cycle, post-write values
        issue(6'd4, 6'd3, 6'd6, 4'd3, 1'b0);
        wb_wr = 1'b1; wb_rd = 6'd3; wb_data = 32'h99;
        next();
        #1;
        chk("t5_stale_stall", hazard_stall, 1);
        chk("t5_valid_c1", out_valid, 0);
        next();
        #1;
        chk("t5_stall_clear", hazard_stall, 0);
        chk("t5_valid_c2", out_valid, 0);
        next();
        #1;
        chk("t5_valid_c3", out_valid, 1);
        chk("t5_out_a", out_a, 32'h55);
        chk("t5_out_b", out_b, 32'h99);
        // Back-to-back: hand off and accept a new instruction in the same cycle
        issue(6'd4, 6'd4, 6'd7, 4'd4, 1'b0);
        #1;
        chk("t5_b2b_in_ready", in_ready, 1);
        next();
        #1;
        chk("t5_b2b_valid_gap", out_valid, 0);
        next();
        #1;
        chk("t5_b2b_valid", out_valid, 1);
        chk("t5_b2b_a", out_a, 32'h55);
        chk("t5_b2b_rd", out_rd, 7);
        next();

        // Held bundle with rs==rt under backpressure refreshed by write-back, then reset
        issue(6'd3, 6'd3, 6'd9, 4'd2, 1'b1);
        next();
        next();
        out_ready = 1'b0;
        wb_wr = 1'b1; wb_rd = 6'd3; wb_data = 32'h77;
        #1;
        chk("t6_valid", out_valid, 1);
        chk("t6_in_ready_bp", in_ready, 0);
        chk("t6_a_before", out_a, 32'h99);
        chk("t6_b_before", out_b, 32'h99);
        next();
        out_ready = 1'b0;
        wb_wr = 1'b1; wb_rd = 6'd5; wb_data = 32'hEE;
        #1;
        chk("t6_a_fresh", out_a, 32'h77);
        chk("t6_b_fresh", out_b, 32'h77);
        next();
        out_ready = 1'b0;
        #1;
        chk("t6_a_stable", out_a, 32'h77);
        chk("t6_valid_held", out_valid, 1);
        chk("t6_rd", out_rd, 9);
        chk("t6_is_load", out_is_load, 1);
        rst = 1'b1;
        next();
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        chk("t6_rst_a", out_a, 0);
        rst = 1'b0;
        next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
